uart_tx_fifo: RTL

- Serial UART transmitter for the chipset. It is the return path paired with the RXpin boot/receive logic.
- Accepts bytes from the host-side bus through a small FIFO and shifts them out on TXpin as 8N1 frames, LSB first.
- Sits between the chipset register decode (write strobe) and the TXpin board pin. Nominal clock is 4.096 MHz; nominal rate is 115200 baud.

---
 rtl/uart_tx_fifo.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1/8N2 UART transmitter on TXpin.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2 frames).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 36,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf,
    output logic       TXpin
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic pop;
    logic wr_accept;
    logic bit_done;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_done  = (timer_q == T_LAST);
        if (state_q != S_IDLE) begin
            timer_d = bit_done ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    timer_d = '0;
                    shift_d = fifo_mem[head_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_mem[head_q];
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d   = S_STOP;
                        tx_d      = 1'b1;
                        bit_idx_d = '0;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                end
            end
`endif
            S_STOP: begin
                // bit_idx counts stop bits here so 2-stop frames reuse the bit timer
                if (bit_done) begin
                    if (bit_idx_q == STOP_LAST) begin
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                            tx_d    = 1'b0;
                            shift_d = fifo_mem[head_q];
`ifdef UART_TX_PARITY_EN
                            parity_d = ^fifo_mem[head_q];
`endif
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // A same-edge pop frees a slot, so a write into a full FIFO still lands.
    always_comb begin
        wr_accept = wr && (!full_q || pop);
        ovf_d     = ovf_q | (wr && !wr_accept);
        head_d    = pop ? head_q + PW'(1) : head_q;
        tail_d    = wr_accept ? tail_q + PW'(1) : tail_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            fifo_mem[tail_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign busy  = busy_q;
    assign ovf   = ovf_q;
    assign TXpin = tx_q;

endmodule
